// File: rtl/itof_issue_stage.sv
// itof_issue_stage -- buffered issue stage in front of the combinational
// int-to-float converter.
//
// Signed 32-bit requests (with a destination tag) are queued in a DEPTH-entry
// FIFO. The FIFO head feeds the itof block, and the result is captured in a
// result register for FPU writeback. There are valid/ready handshakes on both
// sides. Total capacity is DEPTH+1 entries, and ordering is strictly FIFO.
//
// Optional feature macro: ITOF_ISSUE_BYPASS_EN
//   When this macro is defined, a request accepted while the FIFO is empty and
//   the result register can load skips the FIFO. It is converted and loaded at
//   the accept edge, giving 1-edge latency. When undefined, every request goes
//   through the FIFO, giving latency of at least 2 edges.
//
// Ports
//   clk, rstn             clock, asynchronous active-low reset
//   flush                 synchronous discard of queued and held work
//   in_valid/in_ready     request handshake; in_data (int32), in_tag
//   out_valid/out_ready   result handshake; out_data (fp32), out_tag
//   count                 FIFO occupancy (result register not included)

// itof: combinational signed int32 -> IEEE-754 single.
// Rounds half-up on the first dropped bit. Mantissa overflow bumps the exponent.
module itof (
  input  logic [31:0] a,
  output logic [31:0] f
);
  logic        sign;
  logic [31:0] mag;
  logic [4:0]  lead;
  logic [24:0] norm_top;
  logic [6:0]  norm_unused;
  logic [24:0] sum;
  logic [7:0]  expo;

  always_comb begin
    sign = a[31];
    mag  = sign ? (~a + 32'd1) : a;   // 0x80000000 maps to 2^31 as unsigned
    lead = '0;
    for (int i = 0; i < 32; i++)
      if (mag[i]) lead = 5'(i);
    // Put the leading one at bit 31. Bits 31:8 are the 24-bit significand and
    // bit 7 is the first dropped bit. The remaining low bits do not affect rounding.
    {norm_top, norm_unused} = mag << (5'd31 - lead);
    sum  = {1'b0, norm_top[24:1]} + {24'd0, norm_top[0]};
    expo = 8'd127 + {3'd0, lead} + {7'd0, sum[24]};
    if (mag == '0) f = '0;
    else           f = {sign, expo, (sum[24] ? sum[23:1] : sum[22:0])};
  end
endmodule

module itof_issue_stage #(
  parameter int DEPTH = 4,   // power of two, >= 2
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_data,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } req_t;

  req_t            mem [DEPTH];
  req_t            head;
  logic [AW:0]     wr_ptr, rd_ptr;   // extra MSB distinguishes full from empty
  logic            full, empty;
  logic            push_req, push, pop, can_load, load_en, byp;
  logic [31:0]     conv_a, conv_f;
  logic [TAG_W-1:0] conv_tag;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign count    = wr_ptr - rd_ptr;
  assign head     = mem[rd_ptr[AW-1:0]];

  // A full FIFO blocks accepts even if the result register drains this cycle.
  assign in_ready = rstn & ~flush & ~full;
  assign push_req = in_valid & in_ready;
  assign can_load = ~out_valid | out_ready;
  assign load_en  = can_load & ~empty;
  assign pop      = load_en;

`ifdef ITOF_ISSUE_BYPASS_EN
  // Bypass is mutually exclusive with load_en because it requires an empty FIFO.
  // in_ready already excludes flush, so a flush cycle never bypasses.
  assign byp      = push_req & empty & can_load;
  assign conv_a   = byp ? in_data : head.data;
  assign conv_tag = byp ? in_tag  : head.tag;
`else
  assign byp      = 1'b0;
  assign conv_a   = head.data;
  assign conv_tag = head.tag;
`endif

  assign push = push_req & ~byp;

  // One converter instance is shared by the FIFO head and the bypass path.
  itof u_itof (.a(conv_a), .f(conv_f));

  // The storage array needs no reset because the pointers qualify every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{tag: in_tag, data: in_data};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Result register. Flush wins over load. Data and tag hold while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_en | byp) begin
      out_valid <= 1'b1;
      out_data  <= conv_f;
      out_tag   <= conv_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_itof_issue_stage.sv
// Directed self-checking bench for itof_issue_stage. Results are captured at
// the falling edge whenever a writeback handshake is pending. They are compared
// in order against hand-computed IEEE-754 values.
module tb_itof_issue_stage;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
`ifdef ITOF_ISSUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic                   flush = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   out_ready = 1'b0;
  logic [31:0]            in_data = '0;
  logic [TAG_W-1:0]       in_tag = '0;
  logic                   in_ready, out_valid;
  logic [31:0]            out_data;
  logic [TAG_W-1:0]       out_tag;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0]      got_d[$], exp_d[$];
  logic [TAG_W-1:0] got_t[$], exp_t[$];
  int               got_c[$];

  itof_issue_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A transfer happens at the next rising edge when valid & ready.
  always @(negedge clk)
    if (rstn && !flush && out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_t.push_back(out_tag);
      got_c.push_back(cyc);
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves in_valid high so callers can stream back-to-back.
  task automatic send(input logic [31:0] d, input logic [TAG_W-1:0] t);
    in_data = d; in_tag = t; in_valid = 1'b1;
    tick();
  endtask

  task automatic expect_res(input logic [31:0] d, input logic [TAG_W-1:0] t);
    exp_d.push_back(d);
    exp_t.push_back(t);
  endtask

  task automatic wait_drain(input int n);
    for (int k = 0; k < 20 && got_d.size() < n; k++) tick();
  endtask

  task automatic compare_all(input string tg);
    chk({tg, "_n"}, 32'(got_d.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      chk($sformatf("%s_d%0d", tg, i), got_d[i], exp_d[i]);
      chk($sformatf("%s_t%0d", tg, i), 32'(got_t[i]), 32'(exp_t[i]));
    end
    got_d.delete(); got_t.delete(); got_c.delete();
    exp_d.delete(); exp_t.delete();
  endtask

  initial begin
    // reset
    tick(2);
    chk("rst_in_ready",  32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_count",     32'(count), 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_out_tag",   32'(out_tag), 0);
    rstn = 1'b1;
    #1;
    chk("rel_in_ready",  32'(in_ready), 1);

    // 1: single request, latency
    out_ready = 1'b1;
    expect_res(32'h3F800000, 5'd3);
    send(32'h00000001, 5'd3);
    in_valid = 1'b0;
    chk("t1_valid_e1", 32'(out_valid), 32'(LAT == 1));
    tick();
    chk("t1_valid_e2", 32'(out_valid), 32'(LAT == 2));
    wait_drain(1);
    compare_all("t1");

    // 2: back-to-back, one per cycle
    expect_res(32'hBF800000, 5'd1);
    expect_res(32'h00000000, 5'd2);
    expect_res(32'h4F000000, 5'd4);
    send(32'hFFFFFFFF, 5'd1);
    send(32'h00000000, 5'd2);
    send(32'h7FFFFFFF, 5'd4);
    in_valid = 1'b0;
    wait_drain(3);
    if (got_c.size() == 3) begin
      chk("t2_tput01", 32'(got_c[1] - got_c[0]), 1);
      chk("t2_tput12", 32'(got_c[2] - got_c[1]), 1);
    end else chk("t2_tput_n", 32'(got_c.size()), 3);
    compare_all("t2");

    // 3: rounding and sign corners
    expect_res(32'h4B800001, 5'd5);
    expect_res(32'h4B7FFFFF, 5'd6);
    expect_res(32'hCF000000, 5'd7);
    expect_res(32'hC3800000, 5'd8);
    send(32'h01000001, 5'd5);
    send(32'h00FFFFFF, 5'd6);
    send(32'h80000000, 5'd7);
    send(32'hFFFFFF00, 5'd8);
    in_valid = 1'b0;
    wait_drain(4);
    compare_all("t3");

    // 4: backpressure, fill DEPTH+1, then drain in order
    out_ready = 1'b0;
    expect_res(32'h40000000, 5'd10);
    expect_res(32'h40400000, 5'd11);
    expect_res(32'h40800000, 5'd12);
    expect_res(32'h40A00000, 5'd13);
    expect_res(32'h40C00000, 5'd14);
    for (int i = 0; i < DEPTH + 1; i++) begin
      chk($sformatf("t4_rdy%0d", i), 32'(in_ready), 1);
      send(32'(i + 2), 5'(10 + i));
    end
    in_data = 32'd7; in_tag = 5'd15;          // must not be accepted
    chk("t4_full_rdy", 32'(in_ready), 0);
    chk("t4_full_cnt", 32'(count), DEPTH);
    chk("t4_hold_v",   32'(out_valid), 1);
    chk("t4_hold_d",   out_data, 32'h40000000);
    tick(2);
    chk("t4_hold_d2",  out_data, 32'h40000000);
    chk("t4_hold_t2",  32'(out_tag), 10);
    chk("t4_cnt2",     32'(count), DEPTH);
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain(5);
    tick(2);
    compare_all("t4");

    // 5: flush with 3 queued and a pending request
    out_ready = 1'b0;
    send(32'd8, 5'd1); send(32'd9, 5'd2); send(32'd10, 5'd3); send(32'd11, 5'd4);
    chk("t5_pre_cnt", 32'(count), 3);
    in_data = 32'd99; in_tag = 5'd9; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_cnt",   32'(count), 0);
    chk("t5_valid", 32'(out_valid), 0);
    out_ready = 1'b1;
    tick(6);
    compare_all("t5");
    chk("t5_valid_late", 32'(out_valid), 0);

    // 6: asynchronous reset mid-stream
    out_ready = 1'b0;
    send(32'd20, 5'd1); send(32'd21, 5'd2); send(32'd22, 5'd3);
    in_valid = 1'b0;
    chk("t6_pre_cnt", 32'(count), 2);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_cnt",   32'(count), 0);
    chk("t6_rst_rdy",   32'(in_ready), 0);
    tick();
    rstn = 1'b1;
    tick();
    got_d.delete(); got_t.delete(); got_c.delete();
    out_ready = 1'b1;
    expect_res(32'hC1200000, 5'd7);
    send(32'hFFFFFFF6, 5'd7);
    in_valid = 1'b0;
    wait_drain(1);
    compare_all("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
